// File: rtl/tt_pkg.sv
// Shared types and defaults for the truth-table sweep/capture block.
package tt_pkg;

  localparam int N_IN_DEF = 7;
  localparam int TT_W_DEF = 128;

  typedef logic [TT_W_DEF-1:0] tt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

endpackage : tt_pkg

// File: rtl/tt_lat_pipe.sv
// Valid + minterm-index delay line matching the FUT latency.
// LAT=0 collapses to a plain wire so capture happens in the same cycle as drive.
module tt_lat_pipe #(
  parameter int LAT = 0,
  parameter int W   = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vld_i,
  input  logic [W-1:0] idx_i,
  output logic         vld_o,
  output logic [W-1:0] idx_o
);

  generate
    if (LAT == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign vld_o = vld_i;
      assign idx_o = idx_i;
    end else begin : g_pipe
      logic [LAT-1:0] vld_q;
      logic [W-1:0]   idx_q [LAT];

      // Shift valid and index one stage per clock; reset empties the line.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
        end else begin
          vld_q[0] <= vld_i;
          idx_q[0] <= idx_i;
          for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            idx_q[i] <= idx_q[i-1];
          end
        end
      end

      assign vld_o = vld_q[LAT-1];
      assign idx_o = idx_q[LAT-1];
    end
  endgenerate

endmodule : tt_lat_pipe

// File: rtl/tt_sweep_capture.sv
// Sweeps every input minterm into a combinational/pipelined function-under-test,
// captures its truth table and compares it against a golden table.
// Optional build macro TT_MISMATCH_LOG_EN adds mism_valid/mism_idx, which record
// the lowest minterm whose captured value differs from the golden bit.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; x held at 0, results held
// DRIVE | x steps 0..TT_W-1, one minterm per cycle
// DRAIN | x holds TT_W-1 while the last DUT_LAT results return
// DONE  | one-cycle done pulse; match/tt_out valid
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter  int N_IN    = N_IN_DEF,
  parameter  int DUT_LAT = 0,
  localparam int TT_W    = 2**N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [TT_W-1:0] expected_tt,
  output logic [N_IN-1:0] x,
  input  logic            f_in,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] tt_out,
  output logic            match
`ifdef TT_MISMATCH_LOG_EN
  ,
  output logic            mism_valid,
  output logic [N_IN-1:0] mism_idx
`endif
);

  localparam logic [N_IN-1:0] IDX_MAX    = N_IN'(TT_W - 1);
  localparam logic [15:0]     DRAIN_LOAD = 16'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

  sweep_state_t    state_q, state_d;
  logic [N_IN-1:0] x_q, x_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic [TT_W-1:0] exp_q, exp_d;
  logic            match_q, match_d;
  logic [15:0]     drain_q, drain_d;
  logic            cap_vld;
  logic [N_IN-1:0] cap_idx;
`ifdef TT_MISMATCH_LOG_EN
  logic            mism_valid_q, mism_valid_d;
  logic [N_IN-1:0] mism_idx_q, mism_idx_d;
`endif

  tt_lat_pipe #(
    .LAT (DUT_LAT),
    .W   (N_IN)
  ) u_lat_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .vld_i (state_q == DRIVE),
    .idx_i (x_q),
    .vld_o (cap_vld),
    .idx_o (cap_idx)
  );

  // Register all sweep state; reset discards any partial table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      tt_q    <= '0;
      exp_q   <= '0;
      match_q <= 1'b0;
      drain_q <= '0;
`ifdef TT_MISMATCH_LOG_EN
      mism_valid_q <= 1'b0;
      mism_idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      tt_q    <= tt_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      drain_q <= drain_d;
`ifdef TT_MISMATCH_LOG_EN
      mism_valid_q <= mism_valid_d;
      mism_idx_q   <= mism_idx_d;
`endif
    end
  end

  // Next-state, counters, capture and result computation.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    tt_d    = tt_q;
    exp_d   = exp_q;
    match_d = match_q;
    drain_d = drain_q;
`ifdef TT_MISMATCH_LOG_EN
    mism_valid_d = mism_valid_q;
    mism_idx_d   = mism_idx_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          x_d     = '0;
          tt_d    = '0;
          exp_d   = expected_tt;
          match_d = 1'b0;
`ifdef TT_MISMATCH_LOG_EN
          mism_valid_d = 1'b0;
          mism_idx_d   = '0;
`endif
        end
      end
      DRIVE: begin
        if (x_q == IDX_MAX) begin
          // Counter stops at the last minterm rather than wrapping.
          state_d = (DUT_LAT == 0) ? DONE : DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          x_d = x_q + N_IN'(1);
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = DONE;
        else               drain_d = drain_q - 16'd1;
      end
      DONE: begin
        state_d = IDLE;
        x_d     = '0;
      end
      default: state_d = IDLE;
    endcase

    if (cap_vld) begin
      tt_d[cap_idx] = f_in;
`ifdef TT_MISMATCH_LOG_EN
      // Capture order is ascending, so the first miss is the lowest index.
      if (!mism_valid_q && (f_in != exp_q[cap_idx])) begin
        mism_valid_d = 1'b1;
        mism_idx_d   = cap_idx;
      end
`endif
    end

    // The final capture lands on the same edge that enters DONE, so compare tt_d.
    if (state_d == DONE && state_q != DONE) match_d = (tt_d == exp_q);
  end

  assign x      = x_q;
  assign busy   = (state_q == DRIVE) || (state_q == DRAIN);
  assign done   = (state_q == DONE);
  assign tt_out = tt_q;
  assign match  = match_q;
`ifdef TT_MISMATCH_LOG_EN
  assign mism_valid = mism_valid_q;
  assign mism_idx   = mism_idx_q;
`endif

endmodule : tt_sweep_capture

// File: tb/tb_tt_sweep_capture.sv
// Directed bench: one instance with a combinational FUT, one with a 2-stage FUT.
module tb_tt_sweep_capture;
  import tt_pkg::*;

  localparam tt_t MAJ_TT = {16{8'hE8}};
  localparam tt_t X6_TT  = 128'hFFFFFFFFFFFFFFFF_0000000000000000;
  localparam tt_t F_TT   = 128'hfeeaeaa8eaa8e8a8eae8eaa8eaa8a880;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  tt_t        exp_tt;
  logic       start0, start2;
  logic [6:0] x0, x2;
  logic       f0, f2;
  logic       busy0, busy2, done0, done2, match0, match2;
  tt_t        tt0, tt2;
  int         fmode;
  int         sel;
  logic       r1, r2;
`ifdef TT_MISMATCH_LOG_EN
  logic       mv0, mv2;
  logic [6:0] mi0, mi2;
`endif

  tt_sweep_capture #(.N_IN(7), .DUT_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .expected_tt(exp_tt),
    .x(x0), .f_in(f0), .busy(busy0), .done(done0), .tt_out(tt0), .match(match0)
`ifdef TT_MISMATCH_LOG_EN
    , .mism_valid(mv0), .mism_idx(mi0)
`endif
  );

  tt_sweep_capture #(.N_IN(7), .DUT_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .expected_tt(exp_tt),
    .x(x2), .f_in(f2), .busy(busy2), .done(done2), .tt_out(tt2), .match(match2)
`ifdef TT_MISMATCH_LOG_EN
    , .mism_valid(mv2), .mism_idx(mi2)
`endif
  );

  // Combinational FUT for the zero-latency instance.
  always_comb begin
    case (fmode)
      0:       f0 = (x0[0] & x0[1]) | (x0[0] & x0[2]) | (x0[1] & x0[2]);
      1:       f0 = x0[6];
      default: f0 = 1'b0;
    endcase
  end

  // Two-stage registered FUT for the latency-2 instance.
  always @(posedge clk) begin
    r1 <= F_TT[x2];
    r2 <= r1;
  end
  assign f2 = r2;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Starts a sweep on the selected instance and watches it for ncyc cycles.
  task automatic sweep(input tt_t expv, input bit inject, input int ncyc,
                       output int done_cyc, output int done_cnt, output int busy_in,
                       output int busy_out, output int x_err, output logic match_mid);
    int lat;
    lat = (sel != 0) ? 2 : 0;
    done_cyc = 0; done_cnt = 0; busy_in = 0; busy_out = 0; x_err = 0; match_mid = 1'bx;
    @(negedge clk);
    exp_tt = expv;
    if (sel != 0) start2 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start2 = 1'b0;
    exp_tt = ~expv;
    for (int c = 1; c <= ncyc; c++) begin
      logic d, b;
      logic [6:0] xv;
      d  = (sel != 0) ? done2 : done0;
      b  = (sel != 0) ? busy2 : busy0;
      xv = (sel != 0) ? x2 : x0;
      if (d) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (b) begin
        if (c <= 128 + lat) busy_in++;
        else                busy_out++;
      end
      if (c <= 128 && xv != 7'(c - 1)) x_err++;
      if (c > 128 && c <= 128 + lat && xv != 7'd127) x_err++;
      if (c == 10) match_mid = (sel != 0) ? match2 : match0;
      if (inject && (c == 50 || d)) begin
        if (sel != 0) start2 = 1'b1; else start0 = 1'b1;
      end else begin
        start0 = 1'b0; start2 = 1'b0;
      end
      @(negedge clk);
    end
    start0 = 1'b0; start2 = 1'b0;
  endtask

  int   dc, dn, bi, bo, xe;
  logic mm;
  tt_t  exp_b64;

  initial begin
    start0 = 1'b0; start2 = 1'b0; exp_tt = '0; fmode = 0; sel = 0;
    repeat (3) @(negedge clk);
    check("rst_x0", x0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_match0", match0, 0);
    check("rst_tt0", tt0, 0);
    check("rst_tt2", tt2, 0);
`ifdef TT_MISMATCH_LOG_EN
    check("rst_mv0", mv0, 0);
`endif
    rst_n = 1'b1;

    // 1: majority of x0..x2
    sel = 0; fmode = 0;
    sweep(MAJ_TT, 1'b0, 140, dc, dn, bi, bo, xe, mm);
    check("t1_tt", tt0, MAJ_TT);
    check("t1_match", match0, 1);
    check("t1_done_cyc", dc, 129);
    check("t1_done_cnt", dn, 1);
    check("t1_busy_in", bi, 128);
    check("t1_busy_out", bo, 0);
    check("t1_x_seq", xe, 0);
    check("t1_x_idle", x0, 0);
`ifdef TT_MISMATCH_LOG_EN
    check("t1_mv", mv0, 0);
`endif

    // 2: f = x6, matching then with bit 64 cleared
    fmode = 1;
    sweep(X6_TT, 1'b0, 140, dc, dn, bi, bo, xe, mm);
    check("t2a_tt", tt0, X6_TT);
    check("t2a_match", match0, 1);
    exp_b64 = X6_TT;
    exp_b64[64] = 1'b0;
    sweep(exp_b64, 1'b0, 140, dc, dn, bi, bo, xe, mm);
    check("t2b_match_mid", mm, 0);
    check("t2b_match", match0, 0);
    check("t2b_tt", tt0, X6_TT);
`ifdef TT_MISMATCH_LOG_EN
    check("t2b_mv", mv0, 1);
    check("t2b_mi", mi0, 64);
`endif

    // 3: f = 0 against two set bits
    fmode = 2;
    sweep(128'h420, 1'b0, 140, dc, dn, bi, bo, xe, mm);
    check("t3_match", match0, 0);
    check("t3_tt", tt0, 0);
`ifdef TT_MISMATCH_LOG_EN
    check("t3_mv", mv0, 1);
    check("t3_mi", mi0, 5);
`endif

    // 4: latency-2 FUT
    sel = 1;
    sweep(F_TT, 1'b0, 142, dc, dn, bi, bo, xe, mm);
    check("t4_tt", tt2, F_TT);
    check("t4_match", match2, 1);
    check("t4_done_cyc", dc, 131);
    check("t4_busy_in", bi, 130);
    check("t4_busy_out", bo, 0);
    check("t4_x_seq", xe, 0);

    // 5: start at cycle 50 and during DONE is ignored
    sel = 0; fmode = 0;
    sweep(MAJ_TT, 1'b1, 150, dc, dn, bi, bo, xe, mm);
    check("t5_done_cnt", dn, 1);
    check("t5_done_cyc", dc, 129);
    check("t5_busy_out", bo, 0);
    check("t5_tt", tt0, MAJ_TT);

    // 6: reset in the middle of a sweep
    @(negedge clk);
    exp_tt = MAJ_TT; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (39) @(negedge clk);
    check("t6_busy_pre", busy0, 1);
    check("t6_x_pre", x0, 39);
    rst_n = 1'b0;
    #1;
    check("t6_x_rst", x0, 0);
    check("t6_busy_rst", busy0, 0);
    check("t6_tt_rst", tt0, 0);
    check("t6_match_rst", match0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(MAJ_TT, 1'b0, 140, dc, dn, bi, bo, xe, mm);
    check("t6_done_cyc", dc, 129);
    check("t6_tt", tt0, MAJ_TT);
    check("t6_match", match0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_tt_sweep_capture
